// File: rtl/fft_unload_if.sv
// fft_unload_if: FFT output bus in, single-bin valid/ready stream out, plus status
interface fft_unload_if #(parameter int WIDTH = 16, parameter int N = 16);
  logic                   frame_start;
  logic [N*WIDTH-1:0]     in_re, in_im;
  logic                   out_valid, out_ready;
  logic [WIDTH-1:0]       out_re, out_im;
  logic [$clog2(N)-1:0]   out_index;
  logic                   out_last, busy, overrun;
  logic [7:0]             drop_count;
  modport master (input frame_start, in_re, in_im, out_ready,
                  output out_valid, out_re, out_im, out_index, out_last, busy, overrun, drop_count);
  modport slave  (output frame_start, in_re, in_im, out_ready,
                  input out_valid, out_re, out_im, out_index, out_last, busy, overrun, drop_count);
endinterface

// File: rtl/fft_frame_unloader.sv
// fft_frame_unloader: snapshots all FFT bins after a fixed latency and streams them one per beat
module fft_frame_unloader #(
  parameter int WIDTH   = 16,
  parameter int N       = 16,
  parameter int LATENCY = 4
) (
  input logic         clk,
  input logic         rst,
  fft_unload_if.master bus
);
  localparam int IW = $clog2(N);
  localparam logic [7:0] LD = LATENCY > 0 ? 8'(LATENCY - 1) : 8'd0;
  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;
  state_t             state;
  logic [7:0]         cnt;
  logic [IW-1:0]      idx;
  logic [N*WIDTH-1:0] snap_re, snap_im;
  logic               fin, accept, drop;
  // a frame_start on the final handshake starts the next frame back-to-back
  assign fin    = state == STREAM && bus.out_ready && idx == IW'(N - 1);
  assign accept = bus.frame_start && (state == IDLE || fin);
  assign drop   = bus.frame_start && !accept;
  assign bus.out_valid = state == STREAM;
  assign bus.busy      = state != IDLE;
  assign bus.out_index = idx;
  assign bus.out_last  = bus.out_valid && idx == IW'(N - 1);
  assign bus.out_re    = bus.out_valid ? snap_re[idx*WIDTH +: WIDTH] : '0;
  assign bus.out_im    = bus.out_valid ? snap_im[idx*WIDTH +: WIDTH] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      snap_re        <= '0;
      snap_im        <= '0;
      bus.overrun    <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      bus.overrun <= drop;
      if (drop && bus.drop_count != 8'hff) bus.drop_count <= bus.drop_count + 8'd1;
      if (accept && LATENCY == 0) begin
        snap_re <= bus.in_re;
        snap_im <= bus.in_im;
        idx     <= '0;
        state   <= STREAM;
      end else if (accept) begin
        cnt   <= LD;
        idx   <= '0;
        state <= WAIT;
      end else if (state == WAIT) begin
        if (cnt == 8'd0) begin
          snap_re <= bus.in_re;
          snap_im <= bus.in_im;
          idx     <= '0;
          state   <= STREAM;
        end else cnt <= cnt - 8'd1;
      end else if (fin) begin
        idx   <= '0;
        state <= IDLE;
      end else if (state == STREAM && bus.out_ready) idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_fft_frame_unloader.sv
// tb_fft_frame_unloader: random and directed frames on LATENCY=4 and LATENCY=0 units vs a frame-level model
module tb_fft_frame_unloader;
  localparam int W = 16, N = 16;
  logic clk = 0, rst = 0, run = 0;
  logic [N*W-1:0] re, im;
  logic fs[2], rdy[2];
  logic v[2], l[2], b[2], ov[2];
  logic [W-1:0] ro[2], io[2];
  logic [3:0] ix[2];
  logic [7:0] dc[2];
  logic [W-1:0] cur_re[N], cur_im[N], er[N], ei[N];
  int edc[2];
  int n = 0, fails = 0, dmode = 0;
  bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  fft_unload_if #(.WIDTH(W), .N(N)) a ();
  fft_unload_if #(.WIDTH(W), .N(N)) z ();
  fft_frame_unloader #(.WIDTH(W), .N(N), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(a));
  fft_frame_unloader #(.WIDTH(W), .N(N), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(z));

  assign a.in_re = re;
  assign a.in_im = im;
  assign z.in_re = re;
  assign z.in_im = im;
  assign a.frame_start = fs[0];
  assign z.frame_start = fs[1];
  assign a.out_ready = rdy[0];
  assign z.out_ready = rdy[1];
  assign v[0] = a.out_valid;
  assign v[1] = z.out_valid;
  assign l[0] = a.out_last;
  assign l[1] = z.out_last;
  assign b[0] = a.busy;
  assign b[1] = z.busy;
  assign ov[0] = a.overrun;
  assign ov[1] = z.overrun;
  assign ro[0] = a.out_re;
  assign ro[1] = z.out_re;
  assign io[0] = a.out_im;
  assign io[1] = z.out_im;
  assign ix[0] = a.out_index;
  assign ix[1] = z.out_index;
  assign dc[0] = a.drop_count;
  assign dc[1] = z.drop_count;

  always #5 if (run) clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cur;
    for (int i = 0; i < N; i++) begin
      cur_re[i] = dmode != 0 ? W'($urandom) : W'(i * 256);
      cur_im[i] = dmode != 0 ? W'($urandom) : W'(-i);
      re[i*W +: W] = cur_re[i];
      im[i*W +: W] = cur_im[i];
    end
  endtask

  // one frame from the frame_start pulse (skipped when pre=1, i.e. already accepted) to its last beat
  task automatic frame(input int s, input int lat, input int rmode, input int drop_at,
                       input int abort_at, input bit chain, input bit pre);
    int k, c;
    bit r, pend, dropped;
    if (!pre) begin
      load_cur();
      fs[s] = 1;
      tick();
      fs[s] = 0;
    end
    for (int i = 0; i < lat; i++) begin
      chk("wait_valid", v[s], 0);
      chk("wait_busy", b[s], 1);
      chk("wait_overrun", ov[s], 0);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      er[i] = cur_re[i];
      ei[i] = cur_im[i];
    end
    re = {N{16'h7FFF}};
    im = {N{16'h7FFF}};
    k = 0; c = 0; pend = 0; dropped = 0;
    while (k < N && c < 8 * N) begin
      chk("valid", v[s], 1);
      chk("index", ix[s], k);
      chk("re", ro[s], er[k]);
      chk("im", io[s], ei[k]);
      chk("last", l[s], k == N - 1);
      chk("busy", b[s], 1);
      chk("overrun", ov[s], pend);
      chk("drops", dc[s], edc[s]);
      if (k == abort_at) begin
        rst = 1;
        #1;
        chk("abort_valid", v[s], 0);
        chk("abort_drops", dc[s], 0);
        chk("abort_index", ix[s], 0);
        chk("abort_busy", b[s], 0);
        edc = '{0, 0};
        rst = 0;
        return;
      end
      r = rmode == 0 ? 1'b1 : rmode == 1 ? pat[c % 7] : 1'($urandom_range(0, 1));
      if (chain && k == N - 1) r = 1;
      rdy[s] = r;
      pend = 0;
      if (k == drop_at && !dropped) begin
        fs[s] = 1;
        pend = 1;
        dropped = 1;
        if (edc[s] < 255) edc[s]++;
      end
      if (chain && k == N - 1) begin
        load_cur();
        fs[s] = 1;
      end
      tick();
      fs[s] = 0;
      c++;
      if (r) k++;
    end
    chk("stream_done", k, N);
    if (!chain) begin
      chk("end_valid", v[s], 0);
      chk("end_busy", b[s], 0);
      chk("end_last", l[s], 0);
      chk("end_overrun", ov[s], pend);
    end
  endtask

  initial begin
    fs = '{0, 0};
    rdy = '{0, 0};
    edc = '{0, 0};
    re = '0;
    im = '0;
    #3 rst = 1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", v[s], 0);
      chk("rst_re", ro[s], 0);
      chk("rst_im", io[s], 0);
      chk("rst_index", ix[s], 0);
      chk("rst_last", l[s], 0);
      chk("rst_busy", b[s], 0);
      chk("rst_overrun", ov[s], 0);
      chk("rst_drops", dc[s], 0);
    end
    rst = 0;
    run = 1;
    repeat (3) begin
      tick();
      chk("idle_valid", v[0], 0);
      chk("idle_valid0", v[1], 0);
    end
    frame(0, 4, 0, -1, -1, 0, 0);
    frame(0, 4, 1, -1, -1, 0, 0);
    dmode = 1;
    frame(0, 4, 2, 5, -1, 0, 0);
    frame(0, 4, 0, 3, -1, 0, 0);
    frame(0, 4, 0, -1, -1, 1, 0);
    frame(0, 4, 2, -1, -1, 0, 1);
    frame(1, 0, 0, -1, -1, 1, 0);
    frame(1, 0, 1, -1, -1, 1, 1);
    frame(1, 0, 2, 9, -1, 0, 1);
    frame(0, 4, 0, -1, 7, 0, 0);
    frame(0, 4, 2, -1, -1, 0, 0);
    for (int it = 0; it < 6; it++) begin
      int s;
      s = $urandom_range(0, 1);
      frame(s, s != 0 ? 0 : 4, $urandom_range(0, 2), $urandom_range(0, N - 2), -1, 0, 0);
    end
    fs[1] = 1;
    rdy[1] = 0;
    repeat (300) tick();
    fs[1] = 0;
    chk("sat_overrun", ov[1], 1);
    chk("sat_drops", dc[1], 255);
    tick();
    chk("sat_overrun_clear", ov[1], 0);
    chk("sat_drops_hold", dc[1], 255);
    rdy[1] = 1;
    repeat (N) tick();
    chk("sat_drain_valid", v[1], 0);
    chk("sat_drain_busy", b[1], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/fft_frame_unloader.md
# fft_frame_unloader

Output-side companion to the 16-point FFT core. It waits a fixed pipeline latency after a frame is applied to the FFT's parallel inputs, then snapshots all N complex output bins at once. It streams them one bin per cycle over a valid/ready interface in natural index order, so a downstream consumer (UART/FIFO/host DMA) can read the spectrum without a 32-bus-wide tap. Values are passed through unmodified in the codebase's Q8.8 signed format.

## Interface
- WIDTH, 16: bits per real or imaginary component (signed Q8.8).
- N, 16: number of bins per frame, power of two, at least 2.
- LATENCY, 4: FFT pipeline depth in clk cycles, counted from the frame_start edge to the edge at which outputs are valid. Range 0..255.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: a new frame is present on the FFT inputs this cycle.
- in_re  in  N*WIDTH  FFT real outputs, bin k at [k*WIDTH +: WIDTH].
- in_im  in  N*WIDTH  FFT imaginary outputs, same packing.
- out_valid  out  1  out_re, out_im, out_index and out_last are valid.
- out_ready  in  1  consumer accepts the current bin.
- out_re  out  WIDTH  real part of current bin.
- out_im  out  WIDTH  imaginary part of current bin.
- out_index  out  $clog2(N)  bin number of current beat.
- out_last  out  1  high with out_valid on bin N-1.
- busy  out  1  high in WAIT or STREAM.
- overrun  out  1  one-cycle pulse when a frame_start is dropped.
- drop_count  out  8  saturating count of dropped frames; cleared only by rst.

## Operation
- States: IDLE, WAIT, STREAM. A down-counter runs in WAIT, an index counter runs in STREAM, and a 2*N*WIDTH snapshot register holds the captured frame.
- IDLE + frame_start, LATENCY>=1: load wait counter with LATENCY-1 and go to WAIT.
- IDLE + frame_start, LATENCY=0: capture in_re/in_im on the same edge, set index to 0, go to STREAM.
- WAIT: decrement the counter each edge. On the edge where the counter reads 0, capture in_re/in_im, set index to 0, go to STREAM.
- STREAM:
  - out_valid=1; out_re/out_im come from the snapshot at out_index.
  - On out_valid&&out_ready, index increments.
  - The handshake on index N-1 returns the block to IDLE.
- Beat outputs hold stable while out_valid&&!out_ready. No index is skipped or repeated.
- A frame_start in WAIT or STREAM is dropped: overrun=1 for that cycle and drop_count increments (saturating at 255). In-flight frame is unaffected.
- Exception: a frame_start coinciding with the final handshake (index N-1, out_ready=1) is accepted as if in IDLE.
- The snapshot is taken once per frame. in_re/in_im changes after the capture edge have no effect on the stream.
- No arithmetic on data; index wraps by return to IDLE, never by overflow.
- rst asynchronous: state IDLE; counters, snapshot and drop_count 0. All outputs 0: out_valid, out_re, out_im, out_index, out_last, busy, overrun.
- Reset asserted mid-WAIT/STREAM aborts the frame and discards the snapshot.

## Timing
- Let t0 be the edge sampling frame_start. Capture occurs at edge t0+LATENCY. out_valid rises after that edge, with out_index=0.
- busy rises after t0 and falls after the final handshake edge, unless a new frame is accepted on that edge.
- With out_ready held high, bins 0..N-1 appear on N consecutive cycles.
- Minimum frame period is LATENCY+N cycles (frame_start on the final beat).
- overrun is registered: it is high in the cycle after the edge sampling the dropped frame_start.
- out_last = out_valid && (out_index==N-1), registered with the beat.

## Test plan
- Reset: assert rst mid-cycle with clk stopped. Every output reads 0 immediately; after release, out_valid stays 0 with no frame_start.
- Basic stream (LATENCY=4, ready=1): in_re bin k = k*16'h0100, in_im bin k = -k. frame_start at edge t0 → out_valid first high after t0+4. Index 0..15 on consecutive cycles with out_re=k<<8, out_im=-k; out_last only at 15; busy low after beat 15.
- Backpressure: out_ready pattern 1,0,0,1,1,0,1… over a full frame. All 16 bins appear exactly once in order, and the beat is held unchanged during every ready=0 cycle.
- Snapshot isolation: overwrite in_re/in_im with 16'h7FFF one cycle after capture. The streamed values remain k<<8 / -k.
- Overrun, part 1: frame_start while streaming index 5 → overrun pulse, drop_count=1, stream continues to 15 unchanged.
- Overrun, part 2: frame_start on the index-15 handshake is accepted, overrun stays 0, and the next frame's bin 0 appears after 4 further edges. Also repeat with LATENCY=0: bin 0 valid right after the frame_start edge.
- Reset mid-operation: rst during index 7 → out_valid drops asynchronously and drop_count=0. The next frame_start streams from index 0 with freshly captured data.
